// File: rtl/button_pkg.sv
// Shared types and helpers for the front-panel push-button decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package button_pkg;

  // All gesture and debounce timers share this width.
  localparam int TIMER_W = 32;

  // Gesture classifier states.
  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HELD
  } state_t;

  // Converts a millisecond interval to clock cycles. The Hz value is
  // divided first so that large clocks do not overflow 32 bits.
  function automatic logic [TIMER_W-1:0] ms_to_cycles(
    input logic [TIMER_W-1:0] clk_hz,
    input logic [TIMER_W-1:0] ms
  );
    return (clk_hz / TIMER_W'(1000)) * ms;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises the raw active-low button and debounces it into a press level.
// Latency: debounce_cycles+2 clocks from a clean raw edge to pressed changing.
// Backpressure: none; free-running, independent of gesture enable.
//
// Ports:
//   clock     module clock
//   reset     asynchronous active-high reset
//   button_n  raw button, active low, asynchronous to clock
//   pressed   debounced level, 1 = button down
module button_debounce
  import button_pkg::*;
#(
  parameter logic [TIMER_W-1:0] debounce_cycles = TIMER_W'(250000)
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  output logic pressed
);

  // The count is compared before increment, so the flip happens on the
  // edge where the mismatch has persisted for debounce_cycles clocks.
  localparam logic [TIMER_W-1:0] DEBOUNCE_LAST = debounce_cycles - TIMER_W'(1);

  logic                 sync_q1;
  logic                 sync_q2;
  logic                 level;
  logic [TIMER_W-1:0]   count_q;

  // Synchroniser resets to the released level (button_n high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= button_n;
      sync_q2 <= sync_q1;
    end
  end

  assign level = ~sync_q2;

  // Any return to agreement clears the count, so short bounces never
  // accumulate toward a level change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      pressed <= 1'b0;
    end else if (level == pressed) begin
      count_q <= '0;
    end else if (count_q == DEBOUNCE_LAST) begin
      count_q <= '0;
      pressed <= level;
    end else begin
      count_q <= count_q + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/button_decoder.sv
// Classifies debounced button gestures as short, long or double presses.
// Latency: pulses are combinational from registered state; debounce adds debounce_cycles+2.
// Backpressure: none; single-cycle pulses, suppressed entirely while enable is low.
//
// Ports:
//   clock         module clock
//   reset         asynchronous active-high reset
//   button_n      raw button, active low, asynchronous
//   enable        gesture detection enable
//   pressed       debounced level, 1 = button down
//   held          high while a long press is still held
//   short_press   one-cycle pulse
//   long_press    one-cycle pulse
//   double_press  one-cycle pulse
module button_decoder
  import button_pkg::*;
#(
  parameter int unsigned clock_speed = 25000000,
  parameter int unsigned debounce_ms = 10,
  parameter int unsigned long_ms     = 1000,
  parameter int unsigned double_ms   = 300
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  input  logic enable,
  output logic pressed,
  output logic held,
  output logic short_press,
  output logic long_press,
  output logic double_press
);

  localparam logic [TIMER_W-1:0] DEBOUNCE_CYCLES = ms_to_cycles(clock_speed, debounce_ms);
  localparam logic [TIMER_W-1:0] LONG_CYCLES     = ms_to_cycles(clock_speed, long_ms);
  localparam logic [TIMER_W-1:0] DOUBLE_CYCLES   = ms_to_cycles(clock_speed, double_ms);
  localparam logic [TIMER_W-1:0] LONG_LAST       = LONG_CYCLES - TIMER_W'(1);
  localparam logic [TIMER_W-1:0] DOUBLE_LAST     = DOUBLE_CYCLES - TIMER_W'(1);

  if (DEBOUNCE_CYCLES == '0 || LONG_CYCLES == '0 || DOUBLE_CYCLES == '0) begin : g_bad_timing
    $error("button_decoder: a derived cycle count is zero");
  end

  logic               pressed_q;
  logic               rise;
  logic               fall;
  state_t             state_q;
  state_t             state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;

  button_debounce #(
    .debounce_cycles (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .reset    (reset),
    .button_n (button_n),
    .pressed  (pressed)
  );

  assign rise = pressed & ~pressed_q;
  assign fall = ~pressed & pressed_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pressed_q <= pressed;
    end
  end

  // Next-state logic. Every timed state leaves at its terminal count,
  // so the timer never needs saturation.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (!enable) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PRESS1;
            timer_d = '0;
          end
        end
        PRESS1: begin
          if (fall) begin
            state_d = WAIT2;
            timer_d = '0;
          end else if (timer_q == LONG_LAST) begin
            state_d = LONG_HELD;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        WAIT2: begin
          // Rise is tested first so a coincident expiry becomes a double.
          if (rise) begin
            state_d = PRESS2;
            timer_d = '0;
          end else if (timer_q == DOUBLE_LAST) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        PRESS2: begin
          if (fall) state_d = IDLE;
        end
        LONG_HELD: begin
          if (fall) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs. Each pulse term mirrors exactly one exit transition, so at
  // most one can be high in a cycle.
  always_comb begin
    held         = (state_q == LONG_HELD);
    short_press  = enable && (state_q == WAIT2)  && !rise && (timer_q == DOUBLE_LAST);
    long_press   = enable && (state_q == PRESS1) && !fall && (timer_q == LONG_LAST);
    double_press = enable && (state_q == PRESS2) && fall;
  end

endmodule

// File: tb/tb_button_decoder.sv
module tb_button_decoder;
  import button_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic button_n;
  logic enable;
  logic pressed;
  logic held;
  logic short_press;
  logic long_press;
  logic double_press;

  int checks = 0;
  int errors = 0;

  // Monitor bookkeeping: cyc is the index of the cycle currently in progress.
  int cyc = 0;
  logic prev_p = 1'b0;
  int rise_cnt, fall_cnt, rise_cyc, fall_cyc;
  int sp_cnt, lp_cnt, dp_cnt, sp_cyc, lp_cyc, dp_cyc;
  int multi = 0;

  int k0, k1, kr;

  button_decoder #(
    .clock_speed (1000),
    .debounce_ms (4),
    .long_ms     (50),
    .double_ms   (20)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .button_n     (button_n),
    .enable       (enable),
    .pressed      (pressed),
    .held         (held),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press)
  );

  always #5 clock = ~clock;

  // Sample on the active edge: values seen are those of the cycle just ending.
  always @(posedge clock) begin
    if (pressed === 1'b1 && prev_p === 1'b0) begin rise_cnt++; rise_cyc = cyc; end
    if (pressed === 1'b0 && prev_p === 1'b1) begin fall_cnt++; fall_cyc = cyc; end
    prev_p = pressed;
    if (short_press === 1'b1)  begin sp_cnt++; sp_cyc = cyc; end
    if (long_press === 1'b1)   begin lp_cnt++; lp_cyc = cyc; end
    if (double_press === 1'b1) begin dp_cnt++; dp_cyc = cyc; end
    if ((int'(short_press) + int'(long_press) + int'(double_press)) > 1) multi++;
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clr();
    rise_cnt = 0; fall_cnt = 0; rise_cyc = -1; fall_cyc = -1;
    sp_cnt = 0; lp_cnt = 0; dp_cnt = 0; sp_cyc = -1; lp_cyc = -1; dp_cyc = -1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    clr();
    reset    = 1'b1;
    button_n = 1'b1;
    enable   = 1'b1;
    step(3);
    check("rst_pressed", 32'(pressed), 0);
    check("rst_held",    32'(held), 0);
    check("rst_short",   32'(short_press), 0);
    check("rst_long",    32'(long_press), 0);
    check("rst_double",  32'(double_press), 0);
    check("rst_state",   32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    step(5);

    // Bounce rejection: 2-cycle toggles never reach the debounce count.
    clr();
    for (int i = 0; i < 8; i++) begin
      button_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(2);
    end
    button_n = 1'b1;
    step(20);
    check("bounce_rises",  32'(rise_cnt), 0);
    check("bounce_pulses", 32'(sp_cnt + lp_cnt + dp_cnt), 0);

    // Short press.
    clr();
    k0 = cyc; button_n = 1'b0; step(10);
    k1 = cyc; button_n = 1'b1; step(40);
    check("short_rise_lat", 32'(rise_cyc - k0), 6);
    check("short_fall_lat", 32'(fall_cyc - k1), 6);
    check("short_cnt",      32'(sp_cnt), 1);
    check("short_delay",    32'(sp_cyc - fall_cyc), 20);
    check("short_no_long",  32'(lp_cnt), 0);
    check("short_no_dbl",   32'(dp_cnt), 0);

    // Long press.
    clr();
    k0 = cyc; button_n = 1'b0; step(80);
    check("long_held_on", 32'(held), 1);
    check("long_cnt",     32'(lp_cnt), 1);
    check("long_delay",   32'(lp_cyc - rise_cyc), 50);
    button_n = 1'b1; step(30);
    check("long_held_off", 32'(held), 0);
    check("long_no_short", 32'(sp_cnt), 0);
    check("long_no_dbl",   32'(dp_cnt), 0);

    // Double press.
    clr();
    button_n = 1'b0; step(10);
    button_n = 1'b1; step(8);
    button_n = 1'b0; step(10);
    button_n = 1'b1; step(40);
    check("dbl_cnt",      32'(dp_cnt), 1);
    check("dbl_on_fall",  32'(dp_cyc - fall_cyc), 0);
    check("dbl_falls",    32'(fall_cnt), 2);
    check("dbl_no_short", 32'(sp_cnt), 0);
    check("dbl_no_long",  32'(lp_cnt), 0);

    // Enable dropped during WAIT2.
    clr();
    button_n = 1'b0; step(10);
    button_n = 1'b1; step(10);
    check("en_in_wait2", 32'(dut.state_q), 32'(WAIT2));
    enable = 1'b0; step(1);
    check("en_idle", 32'(dut.state_q), 32'(IDLE));
    step(4);
    enable = 1'b1; step(30);
    check("en_no_pulse", 32'(sp_cnt + lp_cnt + dp_cnt), 0);

    // Enable returns while already pressed: no gesture until next rise.
    clr();
    enable = 1'b0; button_n = 1'b0; step(10);
    enable = 1'b1; step(70);
    check("enret_no_long", 32'(lp_cnt), 0);
    check("enret_no_held", 32'(held), 0);
    button_n = 1'b1; step(30);
    check("enret_no_pulse", 32'(sp_cnt + dp_cnt), 0);

    // Reset 20 cycles into PRESS1 with the button held.
    clr();
    k0 = cyc; button_n = 1'b0; step(27);
    check("rm_in_press1", 32'(dut.state_q), 32'(PRESS1));
    reset = 1'b1; #1;
    check("rm_pressed",  32'(pressed), 0);
    check("rm_state",    32'(dut.state_q), 32'(IDLE));
    check("rm_outputs",  32'({held, short_press, long_press, double_press}), 0);
    step(2);
    reset = 1'b0;
    kr = cyc; step(70);
    check("rm_rise_lat",  32'(rise_cyc - kr), 6);
    check("rm_long_cnt",  32'(lp_cnt), 1);
    check("rm_long_dly",  32'(lp_cyc - rise_cyc), 50);
    check("rm_held",      32'(held), 1);
    button_n = 1'b1; step(20);
    check("rm_held_off",  32'(held), 0);
    check("rm_no_other",  32'(sp_cnt + dp_cnt), 0);

    check("one_hot_pulses", 32'(multi), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
